// File: rtl/mem_arbiter_if.sv
// Purpose: bundles fetch, load/store and memory-bus signals of the memory arbiter.
// Latency: none, wiring only.
// Backpressure: carries bus_busy from memcontrol back to the arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction fetch requester
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ack;
   // data load/store requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              err;
   // memory bus towards memcontrol
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_busy;
   logic              bus_valid;
   logic [DATA_W-1:0] bus_rdata;
   // debug view of the arbiter FSM
   logic [1:0]        state;

   // arbiter side: owns the bus and answers both requesters
   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  bus_busy, bus_valid, bus_rdata,
      output i_rdata, i_ack, d_rdata, d_ack, err,
      output bus_req, bus_we, bus_addr, bus_wdata, state
   );

   // environment side: requesters plus memcontrol
   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output bus_busy, bus_valid, bus_rdata,
      input  i_rdata, i_ack, d_rdata, d_ack, err,
      input  bus_req, bus_we, bus_addr, bus_wdata, state
   );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one memory bus between fetch (I) and load/store (D); D has priority, starvation guard for I.
// Latency: 3 cycles req->ack with no busy and bus_valid in first WAIT cycle; 4 cycles minimum per transaction.
// Backpressure: bus_busy holds the command in ISSUE; requesters hold req until their 1-cycle ack.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.master mif
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam int TM_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_q, state_n;

   // latched command and owner (1 = D owns the bus)
   logic              owner_d_q, owner_d_n;
   logic              cmd_we_q, cmd_we_n;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_n;
   logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_n;

   logic [SC_W-1:0]   starve_q, starve_n;
   logic [TM_W-1:0]   timer_q, timer_n;

   // registered outputs
   logic              bus_req_q, bus_req_n;
   logic              i_ack_q, i_ack_n;
   logic              d_ack_q, d_ack_n;
   logic              err_q, err_n;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_n;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_n;

   logic              any_req;
   logic              grant_d;
   logic              timed_out;
   logic              finish;
   logic [DATA_W-1:0] rsp_data;

   // D wins unless fetch has been passed over STARVE_LIMIT times in a row
   assign any_req   = mif.d_req | mif.i_req;
   assign grant_d   = mif.d_req & ~(mif.i_req & (starve_q == SC_W'(STARVE_LIMIT)));
   assign timed_out = (timer_q == TM_W'(TIMEOUT));
   // a real completion beats a timeout that expires in the same cycle
   assign finish    = mif.bus_valid | timed_out;
   assign rsp_data  = mif.bus_valid ? mif.bus_rdata : '0;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_n;
   end

   // next-state decode
   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (any_req)        state_n = ISSUE;
         ISSUE:   if (!mif.bus_busy)  state_n = WAIT;
         WAIT:    if (finish)         state_n = RESP;
         RESP:                        state_n = IDLE;
         default:                     state_n = IDLE;
      endcase
   end

   // next values of the command latches, counters and registered outputs
   always_comb begin
      owner_d_n   = owner_d_q;
      cmd_we_n    = cmd_we_q;
      cmd_addr_n  = cmd_addr_q;
      cmd_wdata_n = cmd_wdata_q;
      starve_n    = starve_q;
      timer_n     = timer_q;
      bus_req_n   = 1'b0;
      i_ack_n     = 1'b0;
      d_ack_n     = 1'b0;
      err_n       = 1'b0;
      i_rdata_n   = i_rdata_q;
      d_rdata_n   = d_rdata_q;

      // the guard only counts while fetch is actually waiting
      if (!mif.i_req) starve_n = '0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               bus_req_n = 1'b1;
               owner_d_n = grant_d;
               if (grant_d) begin
                  cmd_we_n    = mif.d_we;
                  cmd_addr_n  = mif.d_addr;
                  cmd_wdata_n = mif.d_wdata;
                  if (mif.i_req && starve_q != SC_W'(STARVE_LIMIT))
                     starve_n = starve_q + SC_W'(1);
               end else begin
                  cmd_we_n    = 1'b0;
                  cmd_addr_n  = mif.i_addr;
                  cmd_wdata_n = '0;
                  starve_n    = '0;
               end
            end
         end
         ISSUE: begin
            // timer holds the count of WAIT cycles including the current one
            bus_req_n = mif.bus_busy;
            timer_n   = TM_W'(1);
         end
         WAIT: begin
            if (finish) begin
               err_n = ~mif.bus_valid;
               if (owner_d_q) begin
                  d_ack_n = 1'b1;
                  if (!cmd_we_q || !mif.bus_valid) d_rdata_n = rsp_data;
               end else begin
                  i_ack_n   = 1'b1;
                  i_rdata_n = rsp_data;
               end
            end else begin
               timer_n = timer_q + TM_W'(1);
            end
         end
         default: ;
      endcase
   end

   // datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_d_q   <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         starve_q    <= '0;
         timer_q     <= '0;
         bus_req_q   <= 1'b0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         err_q       <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         owner_d_q   <= owner_d_n;
         cmd_we_q    <= cmd_we_n;
         cmd_addr_q  <= cmd_addr_n;
         cmd_wdata_q <= cmd_wdata_n;
         starve_q    <= starve_n;
         timer_q     <= timer_n;
         bus_req_q   <= bus_req_n;
         i_ack_q     <= i_ack_n;
         d_ack_q     <= d_ack_n;
         err_q       <= err_n;
         i_rdata_q   <= i_rdata_n;
         d_rdata_q   <= d_rdata_n;
      end
   end

   assign mif.state     = state_q;
   assign mif.bus_req   = bus_req_q;
   assign mif.bus_we    = cmd_we_q;
   assign mif.bus_addr  = cmd_addr_q;
   assign mif.bus_wdata = cmd_wdata_q;
   assign mif.i_ack     = i_ack_q;
   assign mif.i_rdata   = i_rdata_q;
   assign mif.d_ack     = d_ack_q;
   assign mif.d_rdata   = d_rdata_q;
   assign mif.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter.
// Latency: checks the 3-cycle req->ack path, busy stalls and timeout length.
// Backpressure: drives bus_busy stalls and never-completing reads.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

   mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mif (mif.master)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic        exp_i;
      logic [31:0] exp_data;

      rst           = 1'b1;
      mif.i_req     = 1'b1;
      mif.i_addr    = 32'h0000_0040;
      mif.d_req     = 1'b1;
      mif.d_we      = 1'b1;
      mif.d_addr    = 32'h0000_0080;
      mif.d_wdata   = 32'h1111_2222;
      mif.bus_busy  = 1'b0;
      mif.bus_valid = 1'b0;
      mif.bus_rdata = '0;

      // 1: reset with both requests pending
      step();
      step();
      chk("rst_state",   mif.state,     0);
      chk("rst_bus_req", mif.bus_req,   0);
      chk("rst_i_ack",   mif.i_ack,     0);
      chk("rst_d_ack",   mif.d_ack,     0);
      chk("rst_err",     mif.err,       0);
      chk("rst_i_rdata", mif.i_rdata,   0);
      chk("rst_d_rdata", mif.d_rdata,   0);
      chk("rst_addr",    mif.bus_addr,  0);
      chk("rst_wdata",   mif.bus_wdata, 0);
      chk("rst_we",      mif.bus_we,    0);
      mif.i_req = 1'b0;
      mif.d_req = 1'b0;
      rst       = 1'b0;
      step();
      chk("idle_state", mif.state, 0);

      // 2: fetch read, requester drops req right after grant
      mif.i_req  = 1'b1;
      mif.i_addr = 32'h0000_0100;
      step();
      chk("f_issue_state", mif.state,    1);
      chk("f_bus_req",     mif.bus_req,  1);
      chk("f_bus_addr",    mif.bus_addr, 32'h100);
      chk("f_bus_we",      mif.bus_we,   0);
      mif.i_req = 1'b0;
      step();
      chk("f_wait_state", mif.state,   2);
      chk("f_wait_req",   mif.bus_req, 0);
      mif.bus_valid = 1'b1;
      mif.bus_rdata = 32'h0050_0093;
      step();
      chk("f_i_ack",   mif.i_ack,   1);
      chk("f_i_rdata", mif.i_rdata, 32'h0050_0093);
      chk("f_d_ack",   mif.d_ack,   0);
      chk("f_err",     mif.err,     0);
      mif.bus_valid = 1'b0;
      step();
      chk("f_ack_pulse", mif.i_ack,   0);
      chk("f_idle",      mif.state,   0);
      chk("f_rdata_hold", mif.i_rdata, 32'h0050_0093);

      // 3: store stalled by bus_busy for two cycles
      mif.d_req    = 1'b1;
      mif.d_we     = 1'b1;
      mif.d_addr   = 32'h0000_2000;
      mif.d_wdata  = 32'hCAFE_F00D;
      mif.bus_busy = 1'b1;
      step();
      chk("s_issue", mif.state, 1);
      for (int c = 0; c < 2; c++) begin
         step();
         chk("s_hold_state", mif.state,     1);
         chk("s_hold_req",   mif.bus_req,   1);
         chk("s_hold_we",    mif.bus_we,    1);
         chk("s_hold_addr",  mif.bus_addr,  32'h2000);
         chk("s_hold_wdata", mif.bus_wdata, 32'hCAFE_F00D);
      end
      mif.bus_busy = 1'b0;
      step();
      chk("s_wait", mif.state, 2);
      chk("s_wait_req", mif.bus_req, 0);
      mif.bus_valid = 1'b1;
      mif.bus_rdata = 32'hBAD0_BAD0;
      step();
      chk("s_d_ack",   mif.d_ack,   1);
      chk("s_d_rdata", mif.d_rdata, 0);
      chk("s_i_ack",   mif.i_ack,   0);
      mif.bus_valid = 1'b0;
      mif.d_req     = 1'b0;
      step();
      chk("s_idle", mif.state, 0);

      // 4: both requesters held high; guard forces every fifth grant to fetch
      mif.i_req  = 1'b1;
      mif.i_addr = 32'h0000_0400;
      mif.d_req  = 1'b1;
      mif.d_we   = 1'b0;
      mif.d_addr = 32'h0000_0800;
      for (int k = 0; k < 10; k++) begin
         exp_i    = (k == 4) || (k == 9);
         exp_data = 32'h0000_1000 + k;
         step();
         chk("g_issue", mif.state, 1);
         chk("g_addr",  mif.bus_addr, exp_i ? 32'h400 : 32'h800);
         step();
         mif.bus_valid = 1'b1;
         mif.bus_rdata = exp_data;
         step();
         chk("g_i_ack", mif.i_ack, exp_i);
         chk("g_d_ack", mif.d_ack, !exp_i);
         if (exp_i) chk("g_i_rdata", mif.i_rdata, exp_data);
         else       chk("g_d_rdata", mif.d_rdata, exp_data);
         mif.bus_valid = 1'b0;
         step();
      end
      mif.i_req = 1'b0;
      mif.d_req = 1'b0;
      step();

      // 5: load never completes -> timeout after 8 WAIT cycles
      mif.d_req  = 1'b1;
      mif.d_we   = 1'b0;
      mif.d_addr = 32'h0000_3000;
      step();
      chk("t_issue", mif.state, 1);
      step();
      chk("t_wait", mif.state, 2);
      for (int c = 0; c < 7; c++) begin
         step();
         chk("t_still_wait", mif.state, 2);
         chk("t_no_ack",     mif.d_ack, 0);
      end
      step();
      chk("t_state", mif.state,   3);
      chk("t_d_ack", mif.d_ack,   1);
      chk("t_err",   mif.err,     1);
      chk("t_rdata", mif.d_rdata, 0);
      mif.d_req = 1'b0;
      step();
      chk("t_err_clr", mif.err, 0);
      mif.d_req  = 1'b1;
      mif.d_addr = 32'h0000_3004;
      step();
      step();
      mif.bus_valid = 1'b1;
      mif.bus_rdata = 32'h1234_5678;
      step();
      chk("t2_d_ack", mif.d_ack,   1);
      chk("t2_err",   mif.err,     0);
      chk("t2_rdata", mif.d_rdata, 32'h1234_5678);
      mif.bus_valid = 1'b0;
      mif.d_req     = 1'b0;
      step();

      // 6: reset while waiting; the late bus_valid must be ignored
      mif.d_req  = 1'b1;
      mif.d_addr = 32'h0000_5000;
      step();
      step();
      chk("r_wait", mif.state, 2);
      rst           = 1'b1;
      mif.bus_valid = 1'b1;
      mif.bus_rdata = 32'h0000_DEAD;
      step();
      chk("r_state",   mif.state,    0);
      chk("r_d_ack",   mif.d_ack,    0);
      chk("r_err",     mif.err,      0);
      chk("r_bus_req", mif.bus_req,  0);
      chk("r_addr",    mif.bus_addr, 0);
      rst       = 1'b0;
      mif.d_req = 1'b0;
      step();
      chk("r_post_state", mif.state,   0);
      chk("r_post_ack",   mif.d_ack,   0);
      chk("r_post_rdata", mif.d_rdata, 0);
      mif.bus_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
